sound_synth: RTL and testbench
==============================

# sound_synth

Parametrised multi-event tone generator for the game audio path. Each of `NUM_EV` event inputs (good collision, bad collision, …) triggers a fixed-duration tone with its own pitch period. Tones are produced as a sawtooth or square wave on an 8-bit-style DAC bus, with fixed priority and preemption between events. It replaces the single-tone oscillator/DAC-counter pair and sits between the game-logic event strobes and the external R-2R DAC pins.

## Interface
- `DAC_W`, 8: DAC output width, also the phase accumulator width.
- `NUM_EV`, 4: number of event channels; index 0 has the highest priority.
- `PERIOD_W`, 8: width of the per-event step period.
- `DUR_W`, 24: width of the per-event duration in clk cycles.
- `IDX_W`, `$clog2(NUM_EV)` (min 1): width of the active-event index; derived, not overridden.

Ports:
- `clk`, in, 1: clock.
- `nRst`, in, 1: reset, asynchronous, active-low.
- `ev_i`, in, `NUM_EV`: level event requests. The rising edge triggers.
- `period_i`, in, `NUM_EV*PERIOD_W`: step period per event; slice k belongs to event k. Quasi-static.
- `dur_i`, in, `NUM_EV*DUR_W`: tone duration per event, in cycles. Quasi-static.
- `wave_sel_i`, in, 1: 0 selects sawtooth, 1 selects square.
- `mute_i`, in, 1: forces `dac_o` to 0; timing is unaffected.
- `busy_o`, out, 1: a tone is playing.
- `active_ev_o`, out, `IDX_W`: index of the playing event. Holds its last value when idle.
- `done_o`, out, 1: one-cycle pulse when a tone completes naturally.
- `dac_o`, out, `DAC_W`: waveform sample (registered).

## Operation
- **Edge detection:** `ev_prev` is `ev_i` registered. `edge = ev_i & ~ev_prev`. No synchroniser is included, because inputs come from synchronous game logic.
- **States:**
  - `SND_IDLE`: phase = 0, counters = 0.
  - `SND_PLAY`: tone is active.
- **IDLE → PLAY:** taken on any edge with `dur_i[k] != 0`.
  - Lowest asserted index k wins.
  - Latch k, `period_i[k]`, `dur_i[k]`.
  - Clear the period counter, duration counter and phase.
- **Edges with `dur_i[k] == 0`:** ignored entirely. No busy, no done.
- **Preemption in PLAY:** an edge with index j < current k (and `dur_i[j] != 0`) restarts the tone as event j.
  - Counters and phase are cleared.
  - No `done_o` for the preempted tone.
  - Edges with j ≥ k are dropped, including a retrigger of k itself.
- **Pitch:**
  - Period counter counts 0 … P−1, where P = max(latched period, 1). A period of 0 behaves as 1.
  - At P−1 the counter wraps to 0 and the phase increments by 1, modulo 2^`DAC_W`. The phase wraps freely.
- **Waveform:**
  - Sawtooth: `dac_o` = phase.
  - Square: `dac_o` = all ones if phase MSB = 1, else 0.
  - `dac_o` = 0 in IDLE or when `mute_i` = 1.
- **Duration:**
  - The duration counter increments every PLAY cycle.
  - On the PLAY cycle where it equals D−1 (D = latched duration), the next state is IDLE and `done_o` = 1 for the following cycle.
- **Simultaneous completion and edge:** on the final PLAY cycle, a qualifying edge of any index starts the new tone instead of idling.
  - `done_o` is still pulsed, because the old tone finished.
  - `busy_o` stays high.
- **Latched config:** changes to `period_i`/`dur_i` mid-tone have no effect until the next start.

## Timing
- **Reset values:**
  - `busy_o`=0, `active_ev_o`=0, `done_o`=0, `dac_o`=0.
  - State `SND_IDLE`, `ev_prev`=0.
  - An `ev_i` held high through reset release triggers on the first clock.
- **Start latency:** `ev_i` rises and is sampled high at edge t, so `busy_o`=1 and `active_ev_o` are valid after edge t.
- **Busy length:** `busy_o` is high for exactly D cycles. `done_o` is high in the cycle immediately after.
- **First phase step:** the first step lands P cycles after entry. In sawtooth mode, `dac_o` = 1 after edge t+P, where t is the edge that entered PLAY.
- **Sawtooth period:** P·2^`DAC_W` cycles.
- **Asynchronous reset mid-tone:** all outputs go to their reset values immediately. No `done_o`.

## Structure
- **Package `sound_pkg`:**
  - `snd_state_t` enum (`SND_IDLE`, `SND_PLAY`).
  - `wave_t` enum (`WAVE_SAW`=0, `WAVE_SQUARE`=1).
  - Period constants:
    - `PER_GOOD_10M`=89 and `PER_BAD_10M`=156 (10 MHz chip).
    - `PER_GOOD_12M`=107 and `PER_BAD_12M`=188 (12 MHz FPGA).
  - Duration constants `DUR_GOOD`=3_000_000 and `DUR_BAD`=10_000_000.
- **Sub-module `sound_edge_detect`:** parametrised width `W`; outputs one-cycle rising-edge pulses. Instantiated once with `W=NUM_EV`.
- **Remainder stays in `sound_synth`:** priority encoder, FSM, counters and wave shaper.

## Test plan
All scenarios use `NUM_EV`=4, `DAC_W`=8, `PERIOD_W`=8, `DUR_W`=16.

1. **Reset/idle:** with `nRst` low, then released with no events → all outputs 0 for 50 cycles.
2. **Single sawtooth tone:** ev[1] rises with period=3, dur=20 → `busy_o` high for 20 cycles and `active_ev_o`=1; `dac_o` steps 0,1,…,6 every 3 cycles; `done_o` pulses once after the last busy cycle; `dac_o` returns to 0.
3. **Preemption:** ev[2] (dur=100) playing, ev[0] (period=2, dur=10) rises at cycle 40 → `active_ev_o`=0, phase restarts at 0, `busy_o` lasts 10 more cycles, exactly one `done_o`; an ev[3] edge during playback is ignored.
4. **Simultaneous edges and dur=0:**
   - ev[3] and ev[1] rise together → event 1 plays.
   - ev[2] with dur=0 in IDLE → no busy, no done.
5. **Square/mute/wrap:** period=1, dur=600, `wave_sel_i`=1 → `dac_o` toggles 0x00/0xFF every 128 cycles and the phase wraps at 256; `mute_i` high mid-tone → `dac_o`=0 while `busy_o` stays high.
6. **Boundary:**
   - An edge on the final PLAY cycle → `done_o` pulse with `busy_o` continuous into the new tone.
   - Asynchronous reset mid-tone → immediate zeros and no `done_o`.

Source files
------------

// File: rtl/sound_pkg.sv
// sound_pkg: shared types and board constants for the game tone generator.
//   snd_state_t  - tone FSM states
//   wave_t       - waveform select encoding (matches wave_sel_i)
//   PER_* / DUR_* - step periods and tone lengths for the good/bad collision
//                   sounds on the 10 MHz chip and the 12 MHz FPGA build
package sound_pkg;

  typedef enum logic {
    SND_IDLE = 1'b0,
    SND_PLAY = 1'b1
  } snd_state_t;

  typedef enum logic {
    WAVE_SAW    = 1'b0,
    WAVE_SQUARE = 1'b1
  } wave_t;

  localparam int PER_GOOD_10M = 89;
  localparam int PER_BAD_10M  = 156;
  localparam int PER_GOOD_12M = 107;
  localparam int PER_BAD_12M  = 188;

  localparam int DUR_GOOD = 3_000_000;
  localparam int DUR_BAD  = 10_000_000;

endpackage

// File: rtl/sound_edge_detect.sv
// sound_edge_detect: per-bit rising-edge detector.
//   clk, nRst  - clock, async active-low reset
//   sig_i [W]  - level inputs (already synchronous to clk)
//   rise_o [W] - high for the cycle in which sig_i is high and was low on
//                the previous sample
// The history register resets to 0, so a level held high through reset
// release is reported as an edge on the first clock.
module sound_edge_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [W-1:0] sig_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) prev <= '0;
    else       prev <= sig_i;
  end

  assign rise_o = sig_i & ~prev;

endmodule

// File: rtl/sound_synth.sv
// sound_synth: prioritised multi-event tone generator driving an R-2R DAC.
//   clk, nRst    - clock, async active-low reset
//   ev_i         - level event requests, rising edge triggers a tone
//   period_i     - per-event step period (slice k = event k), 0 acts as 1
//   dur_i        - per-event tone length in cycles, 0 disables the event
//   wave_sel_i   - 0 sawtooth, 1 square
//   mute_i       - forces dac_o to 0 without disturbing timing
//   busy_o       - tone playing
//   active_ev_o  - index of the playing (or last played) event
//   done_o       - one-cycle pulse after a tone runs to completion
//   dac_o        - registered waveform sample
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SND_IDLE | silent, phase and counters cleared, waiting for an edge
// SND_PLAY | tone running; lower-index edges preempt, others are dropped
module sound_synth
  import sound_pkg::*;
#(
  parameter  int DAC_W    = 8,
  parameter  int NUM_EV   = 4,
  parameter  int PERIOD_W = 8,
  parameter  int DUR_W    = 24,
  localparam int IDX_W    = (NUM_EV > 1) ? $clog2(NUM_EV) : 1
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic [NUM_EV-1:0]          ev_i,
  input  logic [NUM_EV*PERIOD_W-1:0] period_i,
  input  logic [NUM_EV*DUR_W-1:0]    dur_i,
  input  logic                       wave_sel_i,
  input  logic                       mute_i,
  output logic                       busy_o,
  output logic [IDX_W-1:0]           active_ev_o,
  output logic                       done_o,
  output logic [DAC_W-1:0]           dac_o
);

  snd_state_t state, state_nxt;

  logic [NUM_EV-1:0]   rise;
  logic [NUM_EV-1:0]   qual;
  logic                start_any;
  logic [IDX_W-1:0]    start_idx;
  logic [PERIOD_W-1:0] sel_per;
  logic [DUR_W-1:0]    sel_dur;

  // Both timers are down-counters: per_cnt reloads from per_m1 (P-1) and
  // steps the phase on reaching 0; dur_cnt starts at D-1 and the tone ends
  // on the cycle it reads 0.
  logic [PERIOD_W-1:0] per_m1, per_m1_nxt;
  logic [PERIOD_W-1:0] per_cnt, per_cnt_nxt;
  logic [DUR_W-1:0]    dur_cnt, dur_cnt_nxt;
  logic [DAC_W-1:0]    phase, phase_nxt;
  logic [IDX_W-1:0]    active_nxt;
  logic                done_nxt;
  logic [DAC_W-1:0]    dac_nxt;
  logic                load;
  logic                last_cycle;

  sound_edge_detect #(.W(NUM_EV)) u_edge (
    .clk    (clk),
    .nRst   (nRst),
    .sig_i  (ev_i),
    .rise_o (rise)
  );

  // Events with a zero duration are treated as if the edge never happened.
  always_comb begin
    for (int i = 0; i < NUM_EV; i++) begin
      qual[i] = rise[i] && (dur_i[i*DUR_W +: DUR_W] != '0);
    end
  end

  // Lowest qualifying index wins; scan downward so it is written last.
  always_comb begin
    start_any = 1'b0;
    start_idx = '0;
    for (int i = NUM_EV - 1; i >= 0; i--) begin
      if (qual[i]) begin
        start_any = 1'b1;
        start_idx = IDX_W'(i);
      end
    end
  end

  assign sel_per = period_i[int'(start_idx)*PERIOD_W +: PERIOD_W];
  assign sel_dur = dur_i[int'(start_idx)*DUR_W +: DUR_W];

  assign last_cycle = (state == SND_PLAY) && (dur_cnt == '0);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      SND_IDLE: begin
        if (start_any) begin
          load      = 1'b1;
          state_nxt = SND_PLAY;
        end
      end
      SND_PLAY: begin
        if (last_cycle) begin
          // The old tone finished regardless of what starts next.
          done_nxt = 1'b1;
          if (start_any) load = 1'b1;
          else           state_nxt = SND_IDLE;
        end else if (start_any && (start_idx < active_ev_o)) begin
          load = 1'b1;
        end
      end
      default: state_nxt = SND_IDLE;
    endcase
  end

  always_comb begin
    active_nxt  = active_ev_o;
    per_m1_nxt  = per_m1;
    per_cnt_nxt = per_cnt;
    dur_cnt_nxt = dur_cnt;
    phase_nxt   = phase;
    if (load) begin
      active_nxt  = start_idx;
      per_m1_nxt  = (sel_per == '0) ? '0 : sel_per - PERIOD_W'(1);
      per_cnt_nxt = per_m1_nxt;
      dur_cnt_nxt = sel_dur - DUR_W'(1);
      phase_nxt   = '0;
    end else if (state_nxt == SND_IDLE) begin
      per_m1_nxt  = '0;
      per_cnt_nxt = '0;
      dur_cnt_nxt = '0;
      phase_nxt   = '0;
    end else begin
      dur_cnt_nxt = dur_cnt - DUR_W'(1);
      if (per_cnt == '0) begin
        per_cnt_nxt = per_m1;
        phase_nxt   = phase + DAC_W'(1);
      end else begin
        per_cnt_nxt = per_cnt - PERIOD_W'(1);
      end
    end
  end

  // Shaped from the next phase so dac_o lines up with the phase register.
  always_comb begin
    dac_nxt = '0;
    if ((state_nxt == SND_PLAY) && !mute_i) begin
      if (wave_t'(wave_sel_i) == WAVE_SQUARE) dac_nxt = {DAC_W{phase_nxt[DAC_W-1]}};
      else                                    dac_nxt = phase_nxt;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= SND_IDLE;
      active_ev_o <= '0;
      per_m1      <= '0;
      per_cnt     <= '0;
      dur_cnt     <= '0;
      phase       <= '0;
      done_o      <= 1'b0;
      dac_o       <= '0;
    end else begin
      state       <= state_nxt;
      active_ev_o <= active_nxt;
      per_m1      <= per_m1_nxt;
      per_cnt     <= per_cnt_nxt;
      dur_cnt     <= dur_cnt_nxt;
      phase       <= phase_nxt;
      done_o      <= done_nxt;
      dac_o       <= dac_nxt;
    end
  end

  assign busy_o = (state == SND_PLAY);

endmodule

// File: tb/tb_sound_synth.sv
// tb_sound_synth: directed scenarios plus a randomized run, every cycle
// compared against a tone model expressed as elapsed-time arithmetic.
module tb_sound_synth;

  localparam int NE = 4;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int UW = 16;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             nRst;
  logic [NE-1:0]    ev;
  logic [PW-1:0]    per [NE];
  logic [UW-1:0]    dur [NE];
  logic [NE*PW-1:0] period_v;
  logic [NE*UW-1:0] dur_v;
  logic             wave_sel;
  logic             mute;
  logic             busy_o;
  logic [IW-1:0]    active_ev_o;
  logic             done_o;
  logic [DW-1:0]    dac_o;

  int tests = 0;
  int fails = 0;

  // Model: a tone is (event k, period P, duration D, cycles elapsed n).
  logic [NE-1:0] m_prev;
  bit            m_play;
  int            m_k, m_p, m_d, m_n;
  bit            m_done;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NE; g++) begin : g_pack
    assign period_v[g*PW +: PW] = per[g];
    assign dur_v[g*UW +: UW]    = dur[g];
  end

  sound_synth #(
    .DAC_W(DW), .NUM_EV(NE), .PERIOD_W(PW), .DUR_W(UW)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .ev_i        (ev),
    .period_i    (period_v),
    .dur_i       (dur_v),
    .wave_sel_i  (wave_sel),
    .mute_i      (mute),
    .busy_o      (busy_o),
    .active_ev_o (active_ev_o),
    .done_o      (done_o),
    .dac_o       (dac_o)
  );

  task automatic model_reset();
    m_prev = '0;
    m_play = 0;
    m_k    = 0;
    m_p    = 1;
    m_d    = 0;
    m_n    = 0;
    m_done = 0;
  endtask

  task automatic model_step();
    logic [NE-1:0] e;
    int j;
    if (!nRst) begin
      model_reset();
      return;
    end
    e = ev & ~m_prev;
    m_prev = ev;
    j = -1;
    for (int i = NE - 1; i >= 0; i--) if (e[i] && dur[i] != 0) j = i;
    m_done = 0;
    if (m_play) begin
      if (m_n == m_d - 1) begin
        m_done = 1;
        m_play = 0;
      end else begin
        m_n++;
      end
    end
    if (j >= 0 && (!m_play || j < m_k)) begin
      m_play = 1;
      m_k    = j;
      m_p    = (per[j] == 0) ? 1 : int'(per[j]);
      m_d    = int'(dur[j]);
      m_n    = 0;
    end
  endtask

  function automatic int exp_dac();
    int ph;
    if (!m_play || mute) return 0;
    ph = (m_n / m_p) % 256;
    if (wave_sel) return (ph >= 128) ? 255 : 0;
    return ph;
  endfunction

  task automatic check_all(input string tag);
    logic [DW-1:0] ed;
    logic [IW-1:0] ea;
    ed = DW'(exp_dac());
    ea = IW'(m_k);
    tests++;
    assert (busy_o === m_play) else begin
      fails++;
      $error("FAIL %s busy: got %b want %b", tag, busy_o, m_play);
    end
    tests++;
    assert (active_ev_o === ea) else begin
      fails++;
      $error("FAIL %s active_ev: got %0d want %0d", tag, active_ev_o, ea);
    end
    tests++;
    assert (done_o === m_done) else begin
      fails++;
      $error("FAIL %s done: got %b want %b", tag, done_o, m_done);
    end
    tests++;
    assert (dac_o === ed) else begin
      fails++;
      $error("FAIL %s dac: got %0d want %0d", tag, dac_o, ed);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    nRst = 1'b0;
    ev = '0;
    wave_sel = 1'b0;
    mute = 1'b0;
    for (int i = 0; i < NE; i++) begin
      per[i] = 8'd1;
      dur[i] = 16'd0;
    end
    model_reset();

    // Reset and idle.
    #2;
    check_all("in_reset");
    repeat (3) tick("in_reset");
    nRst = 1'b1;
    repeat (50) tick("idle");

    // Single sawtooth tone on event 1.
    per[1] = 8'd3; dur[1] = 16'd20;
    ev = 4'b0010;
    tick("saw_start");
    repeat (25) tick("saw");
    ev = '0;
    tick("saw_end");

    // Preemption of event 2 by event 0; event 3 edge is dropped.
    per[2] = 8'd5; dur[2] = 16'd100;
    per[0] = 8'd2; dur[0] = 16'd10;
    per[3] = 8'd7; dur[3] = 16'd30;
    ev = 4'b0100;
    tick("pre_start");
    repeat (30) tick("pre_run");
    ev = 4'b1100;
    repeat (9) tick("pre_drop3");
    ev = 4'b1101;
    tick("pre_hit");
    repeat (15) tick("pre_tail");
    ev = '0;
    tick("pre_end");

    // Simultaneous edges, then a zero-duration event.
    per[1] = 8'd4; dur[1] = 16'd8;
    ev = 4'b1010;
    tick("simul");
    repeat (12) tick("simul_run");
    ev = '0;
    tick("simul_end");
    dur[2] = 16'd0;
    ev = 4'b0100;
    repeat (5) tick("dur0");
    ev = '0;
    tick("dur0_end");

    // Square wave with phase wrap and mute mid-tone.
    per[0] = 8'd1; dur[0] = 16'd600;
    wave_sel = 1'b1;
    ev = 4'b0001;
    tick("sq_start");
    repeat (300) tick("sq");
    mute = 1'b1;
    repeat (20) tick("sq_mute");
    mute = 1'b0;
    repeat (290) tick("sq_tail");
    ev = '0;
    wave_sel = 1'b0;
    tick("sq_end");

    // Edge on the final play cycle chains straight into the next tone.
    per[2] = 8'd2; dur[2] = 16'd6;
    per[3] = 8'd3; dur[3] = 16'd10;
    ev = 4'b0100;
    tick("chain_start");
    repeat (5) tick("chain_run");
    ev = 4'b1100;
    tick("chain_edge");
    tests++;
    assert (busy_o === 1'b1 && done_o === 1'b1 && active_ev_o === 2'd3) else begin
      fails++;
      $error("FAIL chain_direct: got busy=%b done=%b ev=%0d want 1 1 3", busy_o, done_o, active_ev_o);
    end
    repeat (12) tick("chain_tail");
    ev = '0;
    tick("chain_end");

    // Asynchronous reset mid-tone, event held through release.
    per[1] = 8'd2; dur[1] = 16'd50;
    ev = 4'b0010;
    tick("ar_start");
    repeat (10) tick("ar_run");
    nRst = 1'b0;
    #1;
    model_reset();
    check_all("ar_async");
    repeat (2) tick("ar_held");
    nRst = 1'b1;
    tick("ar_retrig");
    repeat (55) tick("ar_tail");
    ev = '0;
    tick("ar_end");

    // Randomized traffic with mid-tone config changes.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        int k;
        k = $urandom_range(0, NE - 1);
        per[k] = PW'($urandom_range(0, 5));
        dur[k] = ($urandom_range(0, 4) == 0) ? 16'd0 : UW'($urandom_range(1, 40));
      end
      if ($urandom_range(0, 3) == 0) ev = NE'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) wave_sel = ~wave_sel;
      if ($urandom_range(0, 29) == 0) mute = ~mute;
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
